// File: rtl/hc_dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hc_dpram_arbiter
// Description : Owns the single-port RAM (2**ADDR_W x DATA_W) behind the
//               Xillybus seekable hc_dpram streams. The host side provides
//               seek, write and a 2-entry read-prefetch buffer. The hardware
//               core (HC) side is a req/gnt access port. The RAM performs at
//               most one access per cycle. A 2-state arbiter (HOST/HC)
//               schedules it, with a starvation guard for the HC.
// Options     : `define HC_DPRAM_EOF_EN
//               When defined, the read stream stops at address DEPTH-1 and
//               raises eof. When undefined, eof is tied 0 and reads wrap.
// Ports       :
//   bus_clk_w                   in   clock, rising edge
//   trn_reset_n_w               in   asynchronous active-low reset
//   user_hc_dpram_addr_w        in   seek address
//   user_hc_dpram_addr_update_w in   seek strobe (loads both host pointers)
//   user_w_hc_dpram_open_w      in   write stream open
//   user_w_hc_dpram_wren_w      in   host write strobe
//   user_w_hc_dpram_data_w      in   host write data
//   user_w_hc_dpram_full_w      out  host write backpressure (HC tenure)
//   user_r_hc_dpram_open_w      in   read stream open
//   user_r_hc_dpram_rden_w      in   host read strobe (pops buffer head)
//   user_r_hc_dpram_data_w      out  head of prefetch buffer
//   user_r_hc_dpram_empty_w     out  prefetch buffer empty
//   user_r_hc_dpram_eof_w       out  end of file
//   hc_req / hc_we              in   HC access request / write select
//   hc_addr / hc_wdata          in   HC address / write data
//   hc_gnt                      out  HC access performed this cycle
//   hc_rdata / hc_rvalid        out  HC read data, valid 1 cycle after a
//                                    granted read
// Revision    : 1.0 - initial release
// ============================================================================
module hc_dpram_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int HC_MAX_WAIT = 8,
  parameter int HC_BURST    = 4
) (
  input  logic              bus_clk_w,
  input  logic              trn_reset_n_w,
  input  logic [ADDR_W-1:0] user_hc_dpram_addr_w,
  input  logic              user_hc_dpram_addr_update_w,
  input  logic              user_w_hc_dpram_open_w,
  input  logic              user_w_hc_dpram_wren_w,
  input  logic [DATA_W-1:0] user_w_hc_dpram_data_w,
  output logic              user_w_hc_dpram_full_w,
  input  logic              user_r_hc_dpram_open_w,
  input  logic              user_r_hc_dpram_rden_w,
  output logic [DATA_W-1:0] user_r_hc_dpram_data_w,
  output logic              user_r_hc_dpram_empty_w,
  output logic              user_r_hc_dpram_eof_w,
  input  logic              hc_req,
  input  logic              hc_we,
  input  logic [ADDR_W-1:0] hc_addr,
  input  logic [DATA_W-1:0] hc_wdata,
  output logic              hc_gnt,
  output logic [DATA_W-1:0] hc_rdata,
  output logic              hc_rvalid
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam int WAIT_W  = $clog2(HC_MAX_WAIT + 1);
  localparam int BURST_W = $clog2(HC_BURST + 1);

  typedef enum logic [0:0] {
    ST_HOST = 1'b0,
    ST_HC   = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_buf0;      // buffer head
  logic [DATA_W-1:0]   r_buf1;
  logic [1:0]          r_count;     // valid entries in the buffer (0..2)
  logic                r_inflight;  // fetch issued last cycle, data in r_ram_q
  logic [DATA_W-1:0]   r_ram_q;     // registered RAM read port
  logic                r_hc_rvalid;
  logic [WAIT_W-1:0]   r_wait;
  logic [BURST_W-1:0]  r_burst;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                w_in_host;
  logic                w_in_hc;
  logic                w_upd;
  logic                w_ropen;
  logic                w_empty;
  logic                w_pop;
  logic [1:0]          w_occ;
  logic                w_room;
  logic [1:0]          w_fetch_ofs;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic                w_fetch_ok;
  logic                w_host_wr_req;
  logic                w_fetch_req;
  logic                w_force;
  logic                w_to_hc;
  logic                w_host_wr;
  logic                w_fetch;
  logic                w_gnt;
  logic                w_hc_wr;
  logic                w_hc_rd;
  logic                w_flush;
  logic                w_push;
  logic [1:0]          w_push_slot;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic                w_ram_we;
  logic                w_ram_rd;

  assign w_in_host = (r_state == ST_HOST);
  assign w_in_hc   = (r_state == ST_HC);
  assign w_upd     = user_hc_dpram_addr_update_w;
  assign w_ropen   = user_r_hc_dpram_open_w;

  // A closed read stream always reports empty, even before the flush lands.
  assign w_empty = (r_count == 2'd0) | ~w_ropen;

  // A seek in the same cycle wins over a pop or a write.
  assign w_pop = user_r_hc_dpram_rden_w & ~w_empty & ~w_upd;

  // Occupancy after this cycle's pop, counting the word still in flight.
  // Using the post-pop value lets a pop and a fetch overlap, which sustains
  // one word per cycle under continuous rden.
  assign w_occ  = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
  assign w_room = (w_occ < 2'd2);

  // Next word to fetch sits after the buffered and in-flight words.
  assign w_fetch_ofs = r_count + {1'b0, r_inflight};

`ifdef HC_DPRAM_EOF_EN
  // r_rd_end marks that the read pointer wrapped past DEPTH-1.
  logic              r_rd_end;
  logic [ADDR_W:0]   w_fetch_idx;

  assign w_fetch_idx  = {1'b0, r_rd_addr} + {{(ADDR_W-1){1'b0}}, w_fetch_ofs};
  assign w_fetch_addr = w_fetch_idx[ADDR_W-1:0];
  // Never fetch beyond the last address, nor at all once wrapped.
  assign w_fetch_ok   = ~w_fetch_idx[ADDR_W] & ~r_rd_end;
`else
  assign w_fetch_addr = r_rd_addr + {{(ADDR_W-2){1'b0}}, w_fetch_ofs};
  assign w_fetch_ok   = 1'b1;
`endif

  // Write strobes only carry data while the write stream is open.
  assign w_host_wr_req = w_in_host & user_w_hc_dpram_wren_w &
                         user_w_hc_dpram_open_w & ~w_upd;

  assign w_fetch_req = w_in_host & w_ropen & ~w_upd & ~w_host_wr_req &
                       w_room & w_fetch_ok;

  // Starvation guard: after HC_MAX_WAIT cycles of waiting the HC takes the
  // RAM even if the host is busy.
  assign w_force = hc_req & (r_wait == WAIT_W'(HC_MAX_WAIT));
  assign w_to_hc = w_in_host & hc_req &
                   (~(w_host_wr_req | w_fetch_req) | w_force);

  // Host accesses are dropped in the switch cycle so the tenure change is
  // clean; the HC is only granted from the following cycle on.
  assign w_host_wr = w_host_wr_req & ~w_to_hc;
  assign w_fetch   = w_fetch_req & ~w_to_hc;

  assign w_gnt   = w_in_hc & hc_req;
  assign w_hc_wr = w_gnt & hc_we;
  assign w_hc_rd = w_gnt & ~hc_we;

  // Any RAM write may alias a buffered word, so drop buffer and in-flight data.
  assign w_flush     = w_upd | ~w_ropen | w_host_wr | w_hc_wr;
  assign w_push      = r_inflight & ~w_flush;
  assign w_push_slot = r_count - {1'b0, w_pop};

  // Single RAM port: HC, host write and host fetch are mutually exclusive.
  always_comb begin
    w_ram_addr  = w_fetch_addr;
    w_ram_wdata = user_w_hc_dpram_data_w;
    if (w_gnt) begin
      w_ram_addr  = hc_addr;
      w_ram_wdata = hc_wdata;
    end else if (w_host_wr) begin
      w_ram_addr  = r_wr_ptr;
    end
  end

  assign w_ram_we = w_host_wr | w_hc_wr;
  assign w_ram_rd = w_fetch | w_hc_rd;

  // --------------------------------------------------------------------------
  // Arbiter FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HOST: begin
        if (w_to_hc) begin
          w_state_nxt = ST_HC;
        end
      end
      ST_HC: begin
        // Leave when the HC is done or this grant completes the burst.
        if (!hc_req || (r_burst == BURST_W'(HC_BURST - 1))) begin
          w_state_nxt = ST_HOST;
        end
      end
      default: w_state_nxt = ST_HOST;
    endcase
  end

  always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
    if (!trn_reset_n_w) begin
      r_state <= ST_HOST;
      r_wait  <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_hc) begin
        r_wait  <= '0;
        r_burst <= w_gnt ? (r_burst + BURST_W'(1)) : r_burst;
      end else begin
        r_burst <= '0;
        if (hc_req && (r_wait != WAIT_W'(HC_MAX_WAIT))) begin
          r_wait <= r_wait + WAIT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Host pointers and prefetch buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
    if (!trn_reset_n_w) begin
      r_wr_ptr    <= '0;
      r_rd_addr   <= '0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_count     <= '0;
      r_inflight  <= 1'b0;
      r_ram_q     <= '0;
      r_hc_rvalid <= 1'b0;
    end else begin
      if (w_upd) begin
        r_wr_ptr  <= user_hc_dpram_addr_w;
        r_rd_addr <= user_hc_dpram_addr_w;
      end else begin
        if (w_host_wr) begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
        if (w_pop) begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
      end

      r_inflight  <= w_fetch;
      r_hc_rvalid <= w_hc_rd;

      if (w_ram_rd) begin
        r_ram_q <= r_mem[w_ram_addr];
      end

      if (w_flush) begin
        r_count <= '0;
      end else begin
        r_count <= r_count - {1'b0, w_pop} + {1'b0, w_push};
        if (w_pop) begin
          r_buf0 <= r_buf1;
        end
        // The push lands after the shift; a later assignment wins.
        if (w_push) begin
          if (w_push_slot == 2'd0) begin
            r_buf0 <= r_ram_q;
          end else begin
            r_buf1 <= r_ram_q;
          end
        end
      end
    end
  end

`ifdef HC_DPRAM_EOF_EN
  always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
    if (!trn_reset_n_w) begin
      r_rd_end <= 1'b0;
    end else if (w_upd || !w_ropen) begin
      r_rd_end <= 1'b0;
    end else if (w_pop && (r_rd_addr == {ADDR_W{1'b1}})) begin
      r_rd_end <= 1'b1;
    end
  end

  assign user_r_hc_dpram_eof_w = r_rd_end & (r_count == 2'd0) & w_ropen;
`else
  assign user_r_hc_dpram_eof_w = 1'b0;
`endif

  // RAM array has no reset; contents are undefined after reset.
  always_ff @(posedge bus_clk_w) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= w_ram_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign user_w_hc_dpram_full_w  = w_in_hc;
  assign user_r_hc_dpram_data_w  = r_buf0;
  assign user_r_hc_dpram_empty_w = w_empty;
  assign hc_gnt                  = w_gnt;
  // The shared read register carries HC data in the cycle hc_rvalid is high.
  assign hc_rdata                = r_ram_q;
  assign hc_rvalid               = r_hc_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_hc_dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc_dpram_arbiter
// Description : Directed self-checking bench for hc_dpram_arbiter. Inputs
//               are driven 1 time unit after the rising edge and outputs are
//               sampled on the falling edge. Expected values are
//               hand-computed.
//               Honours `define HC_DPRAM_EOF_EN for the wrap/eof vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc_dpram_arbiter;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 32;
  localparam int HC_MAX_WAIT = 8;
  localparam int HC_BURST    = 4;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic              upd;
  logic              wopen;
  logic              wren;
  logic [DATA_W-1:0] wdata;
  logic              full;
  logic              ropen;
  logic              rden;
  logic [DATA_W-1:0] rdata;
  logic              empty;
  logic              eof;
  logic              hreq;
  logic              hwe;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hgnt;
  logic [DATA_W-1:0] hrdata;
  logic              hrvalid;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int g;

  hc_dpram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .HC_MAX_WAIT (HC_MAX_WAIT),
    .HC_BURST    (HC_BURST)
  ) dut (
    .bus_clk_w                   (clk),
    .trn_reset_n_w               (rst_n),
    .user_hc_dpram_addr_w        (addr),
    .user_hc_dpram_addr_update_w (upd),
    .user_w_hc_dpram_open_w      (wopen),
    .user_w_hc_dpram_wren_w      (wren),
    .user_w_hc_dpram_data_w      (wdata),
    .user_w_hc_dpram_full_w      (full),
    .user_r_hc_dpram_open_w      (ropen),
    .user_r_hc_dpram_rden_w      (rden),
    .user_r_hc_dpram_data_w      (rdata),
    .user_r_hc_dpram_empty_w     (empty),
    .user_r_hc_dpram_eof_w       (eof),
    .hc_req                      (hreq),
    .hc_we                       (hwe),
    .hc_addr                     (haddr),
    .hc_wdata                    (hwdata),
    .hc_gnt                      (hgnt),
    .hc_rdata                    (hrdata),
    .hc_rvalid                   (hrvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Step cycles until hc_gnt is seen at a falling edge, at most max_cyc.
  task automatic wait_gnt(input int max_cyc, output int cyc);
    cyc = 0;
    smp();
    while (!hgnt && cyc < max_cyc) begin
      nxt();
      smp();
      cyc++;
    end
  endtask

  task automatic seek(input logic [ADDR_W-1:0] a);
    addr = a;
    upd  = 1'b1;
    nxt();
    upd  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; upd = 1'b0; wopen = 1'b0; wren = 1'b0;
    wdata = '0; ropen = 1'b0; rden = 1'b0; hreq = 1'b0; hwe = 1'b0;
    haddr = '0; hwdata = '0;

    // ---------------- reset values ----------------
    #23;
    check_value("rst_full",   full,    0);
    check_value("rst_empty",  empty,   1);
    check_value("rst_eof",    eof,     0);
    check_value("rst_data",   rdata,   0);
    check_value("rst_gnt",    hgnt,    0);
    check_value("rst_rvalid", hrvalid, 0);
    check_value("rst_rdata",  hrdata,  0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // ---------------- seek 3, write A,B,C,D ----------------
    wopen = 1'b1;
    seek(5'd3);
    wren = 1'b1; wdata = 32'hA;
    smp(); check_value("wr_full_a", full, 0);
    nxt(); wdata = 32'hB;
    smp(); check_value("wr_full_b", full, 0);
    nxt(); wdata = 32'hC;
    smp(); check_value("wr_full_c", full, 0);
    nxt(); wdata = 32'hD;           // lands at wr_ptr 6
    nxt(); wren = 1'b0;

    // ---------------- seek 3 with read open: latency + A,B,C ----------------
    ropen = 1'b1;
    seek(5'd3);
    smp(); check_value("lat_empty_0", empty, 1);
    nxt();
    smp(); check_value("lat_empty_1", empty, 1);
    nxt();
    smp(); check_value("lat_empty_2", empty, 0);
    check_value("lat_data", rdata, 32'hA);
    nxt();
    rden = 1'b1;
    smp(); check_value("rd_a", rdata, 32'hA);
    nxt();
    smp(); check_value("rd_b", rdata, 32'hB);
    check_value("rd_b_empty", empty, 0);
    nxt();
    smp(); check_value("rd_c", rdata, 32'hC);
    nxt();
    rden = 1'b0;

    // ---------------- coherency: HC writes 0x55 to 4 ----------------
    seek(5'd3);
    repeat (4) nxt();
    smp(); check_value("coh_pre_data", rdata, 32'hA);
    nxt();
    hreq = 1'b1; hwe = 1'b1; haddr = 5'd4; hwdata = 32'h55;
    wait_gnt(20, n);
    check_value("coh_gnt", hgnt, 1);
    check_value("coh_full", full, 1);
    nxt();
    hreq = 1'b0; hwe = 1'b0;
    repeat (6) nxt();
    rden = 1'b1;
    smp(); check_value("coh_rd3", rdata, 32'hA);
    nxt();
    smp(); check_value("coh_rd4", rdata, 32'h55);
    nxt();
    rden = 1'b0;

    // ---------------- HC read of address 6 (wr_ptr advanced to 6) ----------
    hreq = 1'b1; hwe = 1'b0; haddr = 5'd6;
    wait_gnt(20, n);
    check_value("hcrd_gnt", hgnt, 1);
    nxt();
    hreq = 1'b0;
    smp(); check_value("hcrd_rvalid", hrvalid, 1);
    check_value("hcrd_rdata", hrdata, 32'hD);
    nxt();
    smp(); check_value("hcrd_rvalid_pulse", hrvalid, 0);

    // ---------------- starvation guard + burst limit ----------------
    seek(5'd0);
    repeat (4) nxt();
    rden = 1'b1; hreq = 1'b1; hwe = 1'b0; haddr = 5'd0;
    wait_gnt(20, n);
    check_value("stv_gnt", hgnt, 1);
    check_value("stv_wait_bound", (n >= 1 && n <= HC_MAX_WAIT + 2), 1);
    check_value("stv_full", full, 1);
    g = 0;
    while (hgnt && g < 10) begin
      g++;
      nxt();
      smp();
    end
    check_value("stv_burst_len", g, HC_BURST);
    check_value("stv_back_host", full, 0);
    nxt();
    rden = 1'b0; hreq = 1'b0;
    nxt();

    // ---------------- wrap / eof at DEPTH-1 ----------------
    seek(5'd31);
    wren = 1'b1; wdata = 32'h1F1F;
    nxt(); wdata = 32'h0A0A;        // wr_ptr wraps to 0
    nxt(); wren = 1'b0;
    seek(5'd31);
    repeat (4) nxt();
    rden = 1'b1;
    smp(); check_value("wrap_rd31", rdata, 32'h1F1F);
    nxt();
    smp();
`ifdef HC_DPRAM_EOF_EN
    check_value("eof_empty", empty, 1);
    check_value("eof_flag",  eof,   1);
`else
    check_value("wrap_rd0",   rdata, 32'h0A0A);
    check_value("wrap_empty", empty, 0);
    check_value("wrap_eof",   eof,   0);
`endif
    nxt();
    rden = 1'b0;
    smp();
`ifdef HC_DPRAM_EOF_EN
    check_value("eof_hold",       eof,   1);
    check_value("eof_hold_empty", empty, 1);
`else
    check_value("wrap_eof_hold", eof, 0);
`endif
    nxt();
    seek(5'd0);
    smp(); check_value("eof_clear", eof, 0);

    // ---------------- reset during HC burst ----------------
    seek(5'd3);
    repeat (4) nxt();
    smp(); check_value("mrst_pre_empty", empty, 0);
    nxt();
    hreq = 1'b1; hwe = 1'b0; haddr = 5'd3;
    wait_gnt(20, n);
    check_value("mrst_gnt0", hgnt, 1);
    nxt();
    smp(); check_value("mrst_gnt1", hgnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check_value("mrst_gnt",    hgnt,    0);
    check_value("mrst_full",   full,    0);
    check_value("mrst_empty",  empty,   1);
    check_value("mrst_rvalid", hrvalid, 0);
    check_value("mrst_data",   rdata,   0);
    hreq = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
